// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, registered
// coordinate/video-enable outputs and active-low syncs with a trimmable delay.
module vga_sync_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_VIS    = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_VIS    = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int PIPE_DLY = 1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_cnt_q, h_cnt_d;
    logic [9:0]       v_cnt_q, v_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             en_q, en_d;
    logic             frame_start_q, frame_start_d;
    // Bit 0 is the registered raw sync; bits 1..PIPE_DLY are the extra delay.
    logic [PIPE_DLY:0] hs_sr_q, hs_sr_d;
    logic [PIPE_DLY:0] vs_sr_q, vs_sr_d;

    logic tick;
    logic hs_raw;
    logic vs_raw;

    assign tick   = (div_q == DIV_LAST);
    assign hs_raw = !((h_cnt_q >= HS_START) && (h_cnt_q <= HS_END));
    assign vs_raw = !((v_cnt_q >= VS_START) && (v_cnt_q <= VS_END));

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        div_d   = div_q + DIV_W'(1);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick) begin
            div_d = '0;
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        x_d           = h_cnt_q;
        y_d           = v_cnt_q;
        en_d          = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0) && (div_q == '0);
        hs_sr_d[0]    = hs_raw;
        vs_sr_d[0]    = vs_raw;
        for (int i = 1; i <= PIPE_DLY; i++) begin
            hs_sr_d[i] = hs_sr_q[i-1];
            vs_sr_d[i] = vs_sr_q[i-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            en_q          <= 1'b0;
            frame_start_q <= 1'b0;
            hs_sr_q       <= '1;
            vs_sr_q       <= '1;
        end else begin
            div_q         <= div_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            en_q          <= en_d;
            frame_start_q <= frame_start_d;
            hs_sr_q       <= hs_sr_d;
            vs_sr_q       <= vs_sr_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign en          = en_q;
    assign frame_start = frame_start_q;
    assign hsync       = hs_sr_q[PIPE_DLY];
    assign vsync       = vs_sr_q[PIPE_DLY];
    assign pixel_tick  = tick && reset;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing for the tic-tac-toe display.
- Produces the pixel coordinates `x`/`y` and the `en` (video-on) signal consumed by the pixel-colour generator, plus the `hsync`/`vsync` pins driven off-chip.
- Runs from the 100 MHz system clock with an internal pixel-rate enable.
- Sync outputs carry a programmable extra delay that matches the colour path's memory-read latency.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- PIPE_DLY, 1, extra clk cycles of delay on `hsync`/`vsync` relative to `x`/`y`/`en` (0..7)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- x  output  10  current horizontal pixel count (0..H_TOTAL-1)
- y  output  10  current line count (0..V_TOTAL-1)
- en  output  1  high when x<H_VIS and y<V_VIS
- hsync  output  1  horizontal sync, active-low, delayed by PIPE_DLY
- vsync  output  1  vertical sync, active-low, delayed by PIPE_DLY
- pixel_tick  output  1  one-clk strobe marking the last clk of each pixel period
- frame_start  output  1  one-clk pulse at the start of each frame

Behaviour:
- H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525). Both must be <=1024; all counters are 10 bits.
- Internal state: `div` (0..CLK_DIV-1), `h_cnt`, `v_cnt`.
- Each clk, `div` increments and wraps to 0 after CLK_DIV-1.
- `tick` = (div==CLK_DIV-1). With CLK_DIV=1, `tick` is constantly 1.
- On `tick`:
  - `h_cnt` increments; when it is H_TOTAL-1 it wraps to 0 and `v_cnt` advances.
  - `v_cnt` wraps to 0 when it is at V_TOTAL-1 and `h_cnt` wraps.
- `pixel_tick` = tick && reset (combinational); it is 0 while reset is low.
- Output registers load every clk (reset high) from the decode of the current counter values, so `x`/`y`/`en` lag the counters by exactly 1 clk:
  - x <= h_cnt; y <= v_cnt
  - en <= (h_cnt<H_VIS) && (v_cnt<V_VIS)
  - frame_start <= (h_cnt==0) && (v_cnt==0) && (div==0), so it is a single-clk pulse per frame.
- Raw syncs:
  - hs_raw = !(h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1]), i.e. low for x 656..751.
  - vs_raw = !(v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1]), i.e. low for y 490..491.
  - Both are registered with the same 1-clk latency as `x`, then passed through a PIPE_DLY-stage shift register. PIPE_DLY=0 means no extra stages.
  - Total sync latency from the counters is 1+PIPE_DLY clks.
- Reset (reset==0 at a clk edge), at any time including mid-frame:
  - div=0, h_cnt=0, v_cnt=0
  - x=0, y=0, en=0, frame_start=0
  - hsync=1 and vsync=1 (inactive), with every delay stage loaded with 1
- After reset is released, the first edge loads x=0, y=0, en=1, frame_start=1.
- No glitch requirement applies during reset; no partial frame is resumed after reset.
- Simultaneous h and v wrap (h_cnt=799, v_cnt=524, tick): next counter state is (0,0) and `frame_start` fires on the following clk.
- Blanking: `en`=0 across the entire horizontal and vertical blanking regions, including sync and porches.

Test Plan:
- Default params, reset low 5 clks then high → edge 1 gives x=0, y=0, en=1, frame_start=1; x=1 appears 4 clks later; pixel_tick period is 4 clks.
- Run one line → x reaches 799 and wraps to 0 with y=1; line period 3200 clks; hsync low for exactly 384 clks starting PIPE_DLY clks after x becomes 656; en high for 2560 clks per visible line.
- Run one full frame → frame_start period 1,680,000 clks; vsync low for 6400 clks while y=490..491 (plus PIPE_DLY); en=0 for all of y=480..524.
- Assert reset mid-line at x=300, y=200 → next clk x=0, y=0, en=0, hsync=vsync=1; after release the timing restarts exactly as in the first scenario.
- CLK_DIV=1, PIPE_DLY=0 → pixel_tick constantly 1, x increments every clk, hsync transitions on the same clk that x shows 656 and 752.
- PIPE_DLY=3 → hsync falls exactly 3 clks after x first reads 656; x/en timing is unchanged versus PIPE_DLY=0.
